// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
// The state encoding and counter-width helpers are defined once here for all sequencer files.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// The reset value is a parameter so each input can default to its safe level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // capture the asynchronous input through two flops
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/reset_sequencer.sv
// Conditions a reset request and PLL lock into a clean reset, then releases
// N_STAGES downstream reset domains one at a time and flags ready when all are out.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_STAGES  = 3,
    parameter int MIN_HOLD  = 16,
    parameter int STAGE_GAP = 4,
    parameter int DEBOUNCE  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rst_req,
    input  logic                pll_locked,
    output logic [N_STAGES-1:0] rst_out,
    output logic                ready
);

    localparam int CW = cnt_width(max3(MIN_HOLD, STAGE_GAP, DEBOUNCE));
    localparam int IW = cnt_width(N_STAGES);

    localparam logic [CW-1:0]       MIN_HOLD_C = CW'(MIN_HOLD);
    localparam logic [CW-1:0]       GAP_LAST_C = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0]       DEBOUNCE_C = CW'(DEBOUNCE);
    localparam logic [CW-1:0]       CNT_ONE_C  = CW'(1);
    localparam logic [IW-1:0]       IDX_LAST_C = IW'(N_STAGES - 1);
    localparam logic [IW-1:0]       IDX_ONE_C  = IW'(1);
    localparam logic [N_STAGES-1:0] ALL_ONES_C = {N_STAGES{1'b1}};
    localparam logic [N_STAGES-1:0] BIT0_C     = N_STAGES'(1'b1);

    logic req_s;
    logic lock_s;
    logic req_active_s;
    logic abort_s;

    state_t              state_r,   state_nxt_s;
    logic [CW-1:0]       hold_cnt_r, hold_cnt_nxt_s;
    logic [CW-1:0]       gap_cnt_r,  gap_cnt_nxt_s;
    logic [CW-1:0]       deb_cnt_r;
    logic [IW-1:0]       idx_r,      idx_nxt_s;
    logic [N_STAGES-1:0] rst_out_r,  rst_out_nxt_s;
    logic                ready_r,    ready_nxt_s;

    // The request defaults to asserted and lock to absent so reset holds through power-up.
    sync_2ff #(.RST_VAL(1'b1)) u_sync_req (
        .clk (clk),
        .rst (rst),
        .d   (rst_req),
        .q   (req_s)
    );

    sync_2ff #(.RST_VAL(1'b0)) u_sync_lock (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // debounce: any synchronized request restarts the quiet-time count
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt_r <= '0;
        end else if (req_s) begin
            deb_cnt_r <= '0;
        end else if (deb_cnt_r != DEBOUNCE_C) begin
            deb_cnt_r <= deb_cnt_r + CNT_ONE_C;
        end else begin
            deb_cnt_r <= deb_cnt_r;
        end
    end

    assign req_active_s = (deb_cnt_r != DEBOUNCE_C);
    assign abort_s      = req_active_s || !lock_s;

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= HOLD;
            hold_cnt_r <= '0;
            gap_cnt_r  <= '0;
            idx_r      <= '0;
            rst_out_r  <= ALL_ONES_C;
            ready_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            gap_cnt_r  <= gap_cnt_nxt_s;
            idx_r      <= idx_nxt_s;
            rst_out_r  <= rst_out_nxt_s;
            ready_r    <= ready_nxt_s;
        end
    end

    // next-state selection; abort always wins over a release step
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            HOLD: begin
                if ((hold_cnt_r == MIN_HOLD_C) && !req_active_s) begin
                    state_nxt_s = WAIT_LOCK;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            // Absent lock is what this state waits for, so only a request aborts here.
            WAIT_LOCK: begin
                if (req_active_s) begin
                    state_nxt_s = HOLD;
                end else if (lock_s) begin
                    state_nxt_s = RELEASE;
                end else begin
                    state_nxt_s = WAIT_LOCK;
                end
            end
            RELEASE: begin
                if (abort_s) begin
                    state_nxt_s = HOLD;
                end else if ((gap_cnt_r == GAP_LAST_C) && (idx_r == IDX_LAST_C)) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = RELEASE;
                end
            end
            RUN: begin
                if (abort_s) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = HOLD;
            end
        endcase
    end

    // next values of counters and outputs
    always_comb begin
        hold_cnt_nxt_s = hold_cnt_r;
        gap_cnt_nxt_s  = gap_cnt_r;
        idx_nxt_s      = idx_r;
        rst_out_nxt_s  = rst_out_r;
        ready_nxt_s    = ready_r;
        case (state_r)
            HOLD: begin
                rst_out_nxt_s = ALL_ONES_C;
                ready_nxt_s   = 1'b0;
                gap_cnt_nxt_s = '0;
                idx_nxt_s     = '0;
                if (hold_cnt_r != MIN_HOLD_C) begin
                    hold_cnt_nxt_s = hold_cnt_r + CNT_ONE_C;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r;
                end
            end
            WAIT_LOCK: begin
                if (req_active_s) begin
                    rst_out_nxt_s  = ALL_ONES_C;
                    ready_nxt_s    = 1'b0;
                    hold_cnt_nxt_s = '0;
                end else if (lock_s) begin
                    gap_cnt_nxt_s = '0;
                    idx_nxt_s     = '0;
                end else begin
                    gap_cnt_nxt_s = gap_cnt_r;
                end
            end
            RELEASE: begin
                if (abort_s) begin
                    rst_out_nxt_s  = ALL_ONES_C;
                    ready_nxt_s    = 1'b0;
                    hold_cnt_nxt_s = '0;
                end else if (gap_cnt_r == GAP_LAST_C) begin
                    rst_out_nxt_s = rst_out_r & ~(BIT0_C << idx_r);
                    ready_nxt_s   = (idx_r == IDX_LAST_C);
                    idx_nxt_s     = idx_r + IDX_ONE_C;
                    gap_cnt_nxt_s = '0;
                end else begin
                    gap_cnt_nxt_s = gap_cnt_r + CNT_ONE_C;
                end
            end
            RUN: begin
                if (abort_s) begin
                    rst_out_nxt_s  = ALL_ONES_C;
                    ready_nxt_s    = 1'b0;
                    hold_cnt_nxt_s = '0;
                end else begin
                    ready_nxt_s = ready_r;
                end
            end
            default: begin
                rst_out_nxt_s  = ALL_ONES_C;
                ready_nxt_s    = 1'b0;
                hold_cnt_nxt_s = '0;
            end
        endcase
    end

    assign rst_out = rst_out_r;
    assign ready   = ready_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus random
// stimulus, all compared against an elapsed-time reference model.
module tb_reset_sequencer;

    localparam int N_STAGES  = 3;
    localparam int MIN_HOLD  = 16;
    localparam int STAGE_GAP = 4;
    localparam int DEBOUNCE  = 8;

    localparam int M_HOLD = 0;
    localparam int M_WAIT = 1;
    localparam int M_REL  = 2;
    localparam int M_RUN  = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                rst_req = 1'b0;
    logic                pll_locked = 1'b1;
    logic [N_STAGES-1:0] rst_out;
    logic                ready;

    int checks = 0;
    int failures = 0;

    reset_sequencer #(
        .N_STAGES  (N_STAGES),
        .MIN_HOLD  (MIN_HOLD),
        .STAGE_GAP (STAGE_GAP),
        .DEBOUNCE  (DEBOUNCE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rst_req    (rst_req),
        .pll_locked (pll_locked),
        .rst_out    (rst_out),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    // Reference model: quiet time on the synchronized request, time spent in
    // hold, and time elapsed since release began decide the expected outputs.
    logic m_rq1, m_rq2, m_lk1, m_lk2;
    int   m_mode, m_hold, m_rel, m_quiet;

    always @(posedge clk) begin
        if (rst) begin
            m_rq1 <= 1'b1; m_rq2 <= 1'b1; m_lk1 <= 1'b0; m_lk2 <= 1'b0;
            m_mode <= M_HOLD; m_hold <= 0; m_rel <= 0; m_quiet <= 0;
        end else begin
            m_rq1 <= rst_req; m_rq2 <= m_rq1;
            m_lk1 <= pll_locked; m_lk2 <= m_lk1;
            m_quiet <= m_rq2 ? 0 : ((m_quiet < DEBOUNCE) ? m_quiet + 1 : m_quiet);
            if (m_mode == M_HOLD) begin
                if (m_hold >= MIN_HOLD && m_quiet >= DEBOUNCE) m_mode <= M_WAIT;
                m_hold <= (m_hold < MIN_HOLD) ? m_hold + 1 : m_hold;
            end else if (m_mode == M_WAIT) begin
                if (m_quiet < DEBOUNCE) begin
                    m_mode <= M_HOLD; m_hold <= 0;
                end else if (m_lk2) begin
                    m_mode <= M_REL; m_rel <= 0;
                end
            end else if (m_quiet < DEBOUNCE || !m_lk2) begin
                m_mode <= M_HOLD; m_hold <= 0;
            end else if (m_mode == M_REL) begin
                m_rel <= m_rel + 1;
                if (m_rel + 1 == N_STAGES * STAGE_GAP) m_mode <= M_RUN;
            end
        end
    end

    function automatic logic [N_STAGES-1:0] model_rst_out();
        logic [N_STAGES-1:0] ones;
        ones = '1;
        if (m_mode == M_RUN) return '0;
        if (m_mode == M_REL) return ones << (m_rel / STAGE_GAP);
        return ones;
    endfunction

    function automatic logic model_ready();
        return (m_mode == M_RUN);
    endfunction

    // Expected outputs e edges after rst falls on a clean, locked start.
    function automatic logic [N_STAGES-1:0] clean_rst_out(input int e);
        if (e < 22) return 3'b111;
        if (e < 26) return 3'b110;
        if (e < 30) return 3'b100;
        return 3'b000;
    endfunction

    task automatic test_reset();
        rst = 1'b1; rst_req = 1'b0; pll_locked = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (rst_out !== 3'b111 || ready !== 1'b0) begin
            failures++;
            $display("FAIL reset rst_out=%b ready=%b expected 111/0", rst_out, ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_power_up(input string tag);
        for (int e = 1; e <= 34; e++) begin
            @(negedge clk);
            checks++;
            if (rst_out !== clean_rst_out(e) || ready !== (e >= 30)) begin
                failures++;
                $display("FAIL %s edge=%0d rst_out=%b ready=%b expected %b/%b",
                         tag, e, rst_out, ready, clean_rst_out(e), (e >= 30));
            end
            checks++;
            if (rst_out !== model_rst_out() || ready !== model_ready()) begin
                failures++;
                $display("FAIL %s_model edge=%0d rst_out=%b ready=%b expected %b/%b",
                         tag, e, rst_out, ready, model_rst_out(), model_ready());
            end
        end
    endtask

    task automatic test_late_lock();
        logic [N_STAGES-1:0] exp_v;
        rst = 1'b1; pll_locked = 1'b0; rst_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 100; e++) begin
            @(negedge clk);
            checks++;
            if (rst_out !== 3'b111 || ready !== 1'b0 || rst_out !== model_rst_out()) begin
                failures++;
                $display("FAIL late_lock_wait edge=%0d rst_out=%b ready=%b expected 111/0", e, rst_out, ready);
            end
        end
        pll_locked = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            @(negedge clk);
            exp_v = (e < 7) ? 3'b111 : (e < 11) ? 3'b110 : (e < 15) ? 3'b100 : 3'b000;
            checks++;
            if (rst_out !== exp_v || ready !== (e >= 15) || rst_out !== model_rst_out()) begin
                failures++;
                $display("FAIL late_lock_release edge=%0d rst_out=%b ready=%b expected %b/%b",
                         e, rst_out, ready, exp_v, (e >= 15));
            end
        end
    endtask

    task automatic test_request_in_run();
        logic [N_STAGES-1:0] exp_v;
        logic                exp_rd;
        rst_req = 1'b1;
        for (int e = 1; e <= 36; e++) begin
            @(negedge clk);
            rst_req = 1'b0;
            if (e < 4) begin
                exp_v = 3'b000; exp_rd = 1'b1;
            end else begin
                exp_v = (e < 26) ? 3'b111 : (e < 30) ? 3'b110 : (e < 34) ? 3'b100 : 3'b000;
                exp_rd = (e >= 34);
            end
            checks++;
            if (rst_out !== exp_v || ready !== exp_rd) begin
                failures++;
                $display("FAIL request_in_run edge=%0d rst_out=%b ready=%b expected %b/%b",
                         e, rst_out, ready, exp_v, exp_rd);
            end
            checks++;
            if (rst_out !== model_rst_out() || ready !== model_ready()) begin
                failures++;
                $display("FAIL request_in_run_model edge=%0d rst_out=%b ready=%b expected %b/%b",
                         e, rst_out, ready, model_rst_out(), model_ready());
            end
        end
    endtask

    task automatic test_bounce();
        int last_high;
        last_high = 0;
        for (int e = 1; e <= 80; e++) begin
            if (e <= 40) rst_req = (((e - 1) / 3) % 2 == 0);
            else rst_req = 1'b0;
            if (rst_req) last_high = e;
            @(negedge clk);
            if (e <= 40 + DEBOUNCE + 2 && e > 3) begin
                checks++;
                if (rst_out !== 3'b111 || ready !== 1'b0) begin
                    failures++;
                    $display("FAIL bounce_hold edge=%0d last_high=%0d rst_out=%b expected 111", e, last_high, rst_out);
                end
            end
            checks++;
            if (rst_out !== model_rst_out() || ready !== model_ready()) begin
                failures++;
                $display("FAIL bounce_model edge=%0d rst_out=%b ready=%b expected %b/%b",
                         e, rst_out, ready, model_rst_out(), model_ready());
            end
        end
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL bounce_final ready=%b expected 1", ready);
        end
    endtask

    task automatic test_lock_loss();
        bit found;
        rst = 1'b1; rst_req = 1'b0; pll_locked = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        found = 1'b0;
        for (int e = 1; e <= 100 && !found; e++) begin
            @(negedge clk);
            if (rst_out[0] === 1'b0) found = 1'b1;
        end
        checks++;
        if (!found || rst_out !== 3'b110) begin
            failures++;
            $display("FAIL lock_loss_first_release found=%0d rst_out=%b expected 110", found, rst_out);
        end
        pll_locked = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            checks++;
            if (rst_out !== ((e < 3) ? 3'b110 : 3'b111) || ready !== 1'b0) begin
                failures++;
                $display("FAIL lock_loss_abort edge=%0d rst_out=%b ready=%b expected %b/0",
                         e, rst_out, ready, ((e < 3) ? 3'b110 : 3'b111));
            end
        end
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            checks++;
            if (rst_out !== 3'b111 || ready !== 1'b0 || rst_out !== model_rst_out()) begin
                failures++;
                $display("FAIL lock_loss_hold edge=%0d rst_out=%b ready=%b expected 111/0", e, rst_out, ready);
            end
        end
        pll_locked = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            checks++;
            if (rst_out !== model_rst_out() || ready !== model_ready()) begin
                failures++;
                $display("FAIL lock_loss_recover edge=%0d rst_out=%b ready=%b expected %b/%b",
                         e, rst_out, ready, model_rst_out(), model_ready());
            end
        end
    endtask

    task automatic test_sequencer_reset();
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL seq_reset_precondition ready=%b expected 1", ready);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (rst_out !== 3'b111 || ready !== 1'b0) begin
            failures++;
            $display("FAIL seq_reset_edge rst_out=%b ready=%b expected 111/0", rst_out, ready);
        end
        rst = 1'b0;
        test_power_up("seq_reset_release");
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            rst_req = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 199) == 0) pll_locked = ~pll_locked;
            if (!pll_locked && $urandom_range(0, 29) == 0) pll_locked = 1'b1;
            rst = ($urandom_range(0, 499) == 0);
            @(negedge clk);
            checks++;
            if (rst_out !== model_rst_out() || ready !== model_ready()) begin
                failures++;
                $display("FAIL random cycle=%0d rst_out=%b ready=%b expected %b/%b",
                         c, rst_out, ready, model_rst_out(), model_ready());
            end
        end
        rst = 1'b0; rst_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_up("power_up");
        test_late_lock();
        test_request_in_run();
        test_bounce();
        test_lock_loss();
        test_sequencer_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
